// File: rtl/iir_biquad_cascade.sv
// Multi-channel cascade of direct-form-II biquads sharing one multiplier, 5 MAC steps per section.
// Optional feature: define IIR_SAT_EN to saturate w/section outputs and raise sat_flag; otherwise results wrap.
module iir_biquad_cascade #(
    parameter int DATA_W       = 16,
    parameter int COEF_W       = 16,
    parameter int NUM_SECTIONS = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic [CH_W-1:0]                   in_chan,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [CH_W-1:0]                   out_chan,
    input  logic                              cfg_we,
    input  logic [$clog2(5*NUM_SECTIONS)-1:0] cfg_addr,
    input  logic [COEF_W-1:0]                 cfg_wdata,
    input  logic                              clear_state,
    output logic                              busy,
    output logic                              sat_flag
);

    localparam int NCOEF = 5 * NUM_SECTIONS;
    localparam int AW    = $clog2(NCOEF);
    localparam int SEC_W = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam int SH    = COEF_W - 2;
    localparam int P_W   = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + 4;
    localparam logic [SEC_W-1:0]  LAST_SEC = SEC_W'(NUM_SECTIONS - 1);
    localparam logic [COEF_W-1:0] COEF_ONE = {2'b01, {SH{1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                                       state_q, state_d;
    logic [SEC_W-1:0]                             sec_q;
    logic [2:0]                                   step_q;
    logic [CH_W-1:0]                              chan_q;
    logic [DATA_W-1:0]                            x_q;
    logic [DATA_W-1:0]                            w0_q;
    logic signed [ACC_W-1:0]                      acc_q;
    logic [DATA_W-1:0]                            out_data_q;
    logic [CH_W-1:0]                              out_chan_q;
    logic [NCOEF-1:0][COEF_W-1:0]                 coef_q;
    logic [NUM_CHANNELS-1:0][NUM_SECTIONS-1:0][DATA_W-1:0] w1_q, w2_q;

    logic signed [COEF_W-1:0] cb0, cb1, cb2, ca1, ca2, mul_c;
    logic signed [DATA_W-1:0] w1_sel, w2_sel, mul_d;
    logic signed [P_W-1:0]    mc_ext, md_ext, prod;
    logic signed [ACC_W-1:0]  prod_ext, x_ext, acc_d, acc_sh;
    logic [DATA_W-1:0]        res;

    // Coefficients and state of the (channel, section) currently being computed
    always_comb begin
        cb0 = '0; cb1 = '0; cb2 = '0; ca1 = '0; ca2 = '0;
        w1_sel = '0; w2_sel = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (sec_q == s[SEC_W-1:0]) begin
                cb0 = coef_q[s*5];
                cb1 = coef_q[s*5+1];
                cb2 = coef_q[s*5+2];
                ca1 = coef_q[s*5+3];
                ca2 = coef_q[s*5+4];
            end
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int s = 0; s < NUM_SECTIONS; s++) begin
                if (chan_q == c[CH_W-1:0] && sec_q == s[SEC_W-1:0]) begin
                    w1_sel = w1_q[c][s];
                    w2_sel = w2_q[c][s];
                end
            end
        end
    end

    always_comb begin
        mul_c = ca1;
        mul_d = w1_sel;
        case (step_q)
            3'd1:    begin mul_c = ca2; mul_d = w2_sel; end
            3'd2:    begin mul_c = cb0; mul_d = w0_q;   end
            3'd3:    begin mul_c = cb1; mul_d = w1_sel; end
            3'd4:    begin mul_c = cb2; mul_d = w2_sel; end
            default: ;
        endcase
        mc_ext   = {{DATA_W{mul_c[COEF_W-1]}}, mul_c};
        md_ext   = {{COEF_W{mul_d[DATA_W-1]}}, mul_d};
        prod     = mc_ext * md_ext;
        prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
        x_ext    = {{(ACC_W-DATA_W-SH){x_q[DATA_W-1]}}, x_q, {SH{1'b0}}};
        case (step_q)
            3'd0:    acc_d = x_ext - prod_ext;
            3'd1:    acc_d = acc_q - prod_ext;
            3'd2:    acc_d = prod_ext;
            default: acc_d = acc_q + prod_ext;
        endcase
        acc_sh = acc_d >>> SH;
    end

`ifdef IIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic clip;
    logic sat_q;

    always_comb begin
        res  = acc_sh[DATA_W-1:0];
        clip = 1'b0;
        if (acc_sh > SAT_MAX) begin
            res  = SAT_MAX[DATA_W-1:0];
            clip = 1'b1;
        end else if (acc_sh < SAT_MIN) begin
            res  = SAT_MIN[DATA_W-1:0];
            clip = 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_hi;

    always_comb res = acc_sh[DATA_W-1:0];

    assign unused_hi = ^acc_sh[ACC_W-1:DATA_W];
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = MAC;
            end
            MAC:  if (step_q == 3'd4 && sec_q == LAST_SEC) state_d = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q      <= '0;
            step_q     <= '0;
            chan_q     <= '0;
            x_q        <= '0;
            w0_q       <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_chan_q <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            for (int i = 0; i < NCOEF; i++) coef_q[i] <= (i % 5 == 0) ? COEF_ONE : '0;
`ifdef IIR_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // cfg/clear land on the accepting edge, so the new sample already sees them
                    if (cfg_we) begin
                        for (int i = 0; i < NCOEF; i++)
                            if (cfg_addr == i[AW-1:0]) coef_q[i] <= cfg_wdata;
                    end
                    if (clear_state) begin
                        w1_q <= '0;
                        w2_q <= '0;
`ifdef IIR_SAT_EN
                        sat_q <= 1'b0;
`endif
                    end
                    if (in_valid) begin
                        x_q    <= in_data;
                        chan_q <= in_chan;
                        sec_q  <= '0;
                        step_q <= '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (step_q == 3'd1) w0_q <= res;
`ifdef IIR_SAT_EN
                    if ((step_q == 3'd1 || step_q == 3'd4) && clip) sat_q <= 1'b1;
`endif
                    if (step_q == 3'd4) begin
                        x_q    <= res;
                        step_q <= '0;
                        for (int c = 0; c < NUM_CHANNELS; c++) begin
                            for (int s = 0; s < NUM_SECTIONS; s++) begin
                                if (chan_q == c[CH_W-1:0] && sec_q == s[SEC_W-1:0]) begin
                                    w2_q[c][s] <= w1_q[c][s];
                                    w1_q[c][s] <= w0_q;
                                end
                            end
                        end
                        if (sec_q == LAST_SEC) begin
                            out_data_q <= res;
                            out_chan_q <= chan_q;
                        end else begin
                            sec_q <= sec_q + SEC_W'(1);
                        end
                    end else begin
                        step_q <= step_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data = out_data_q;
    assign out_chan = out_chan_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Randomized self-checking bench for iir_biquad_cascade against a plain-arithmetic cascade model.
module tb_iir_biquad_cascade;

    localparam int NS = 4;
    localparam int NC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data, out_data, cfg_wdata;
    logic        in_chan, out_chan;
    logic        cfg_we, clear_state, busy, sat_flag;
    logic [4:0]  cfg_addr;

    iir_biquad_cascade dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .clear_state(clear_state), .busy(busy), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint mc[5*NS];
    longint mw1[NC][NS];
    longint mw2[NC][NS];
    bit     msat;
    longint exp_y;
    int     exp_ch;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: each section is w0 = x - a1*w1 - a2*w2, y = b0*w0 + b1*w1 + b2*w2 in Q2.14
    function automatic longint fix(longint v);
        longint r;
        r = v;
`ifdef IIR_SAT_EN
        if (v > 32767) begin r = 32767; msat = 1'b1; end
        else if (v < -32768) begin r = -32768; msat = 1'b1; end
`else
        r = v & 64'hFFFF;
        if (r >= 32768) r = r - 65536;
`endif
        return r;
    endfunction

    function automatic longint model_run(int ch, longint x);
        longint v, w0;
        v = x;
        for (int s = 0; s < NS; s++) begin
            w0 = fix((v * 16384 - mc[s*5+3] * mw1[ch][s] - mc[s*5+4] * mw2[ch][s]) >>> 14);
            v  = fix((mc[s*5] * w0 + mc[s*5+1] * mw1[ch][s] + mc[s*5+2] * mw2[ch][s]) >>> 14);
            mw2[ch][s] = mw1[ch][s];
            mw1[ch][s] = w0;
        end
        return v;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < NC; c++)
            for (int s = 0; s < NS; s++) begin
                mw1[c][s] = 0;
                mw2[c][s] = 0;
            end
        msat = 1'b0;
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 5*NS; i++) mc[i] = (i % 5 == 0) ? 16384 : 0;
        model_clear();
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 0; in_data = 0; in_chan = 0; out_ready = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; clear_state = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_init();
    endtask

    task automatic cfg_write(input int a, input longint v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a[4:0]; cfg_wdata = v[15:0];
        @(negedge clk);
        cfg_we = 1'b0;
        mc[a] = v;
    endtask

    task automatic clear_st();
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        model_clear();
    endtask

    // Offer a sample (optionally with a same-cycle cfg write / clear) and wait for out_valid
    task automatic push(input int ch, input longint x, input bit do_cfg, input int ca,
                        input longint cv, input bit do_clr);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = x[15:0]; in_chan = ch[0];
        cfg_we = do_cfg; cfg_addr = ca[4:0]; cfg_wdata = cv[15:0]; clear_state = do_clr;
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0; clear_state = 1'b0;
        if (do_cfg) mc[ca] = cv;
        if (do_clr) model_clear();
        exp_y  = model_run(ch, x);
        exp_ch = ch;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("latency", n, 20);
    endtask

    task automatic pop(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        check("out_data", $signed(out_data), exp_y);
        check("out_chan", out_chan, exp_ch);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    task automatic send_exp(input string tag, input int ch, input longint x, input longint want);
        push(ch, x, 1'b0, 0, 0, 1'b0);
        check(tag, $signed(out_data), want);
        pop(0);
    endtask

    initial begin
        longint imp[4];
        longint sat_y;
        bit     sat_f;
        int     r;
        imp[0] = 8192; imp[1] = 4096; imp[2] = 2048; imp[3] = 1024;

        do_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);

        send_exp("pass_1000", 0, 1000, 1000);

        // First-order recursion in section 0: w0 = x + 0.5*w1, y = 0.5*w0
        cfg_write(0, 8192);
        cfg_write(3, -8192);
        clear_st();
        for (int i = 0; i < 4; i++) send_exp("impulse", 0, (i == 0) ? 16384 : 0, imp[i]);

        clear_st();
        for (int i = 0; i < 4; i++) begin
            send_exp("inter_c0", 0, (i == 0) ? 16384 : 0, imp[i]);
            send_exp("inter_c1", 1, 0, 0);
        end

`ifdef IIR_SAT_EN
        sat_y = 32767; sat_f = 1'b1;
`else
        sat_y = -5538; sat_f = 1'b0;
`endif
        cfg_write(3, 0);
        cfg_write(0, 32767);
        clear_st();
        send_exp("sat_out", 0, 30000, sat_y);
        check("sat_flag", sat_flag, sat_f);
        clear_st();
        #1 check("sat_cleared", sat_flag, 0);

        // Backpressure: output held, input and cfg refused while waiting
        cfg_write(0, 16384);
        push(1, 2222, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 16'd100;
                in_valid = 1'b1; in_data = 16'd7;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0; in_valid = 1'b0;
            check("hold_data", $signed(out_data), exp_y);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        pop(0);
        send_exp("cfg_ignored", 0, 1234, 1234);

        // Random coefficients, data, channels, same-cycle cfg/clear and output stalls
        for (int i = 0; i < 5*NS; i++) begin
            if (i % 5 < 3) cfg_write(i, longint'($urandom_range(16383)) - 8192);
            else           cfg_write(i, longint'($urandom_range(8191)) - 4096);
        end
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(7);
            push($urandom_range(1), longint'($urandom_range(65535)) - 32768,
                 r == 0, $urandom_range(5*NS-1), longint'($urandom_range(16383)) - 8192, r == 1);
            pop($urandom_range(3));
            check("rand_sat_flag", sat_flag, msat);
        end

        // Reset in the middle of MAC aborts the sample and restores pass-through/zero state
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd321; in_chan = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_init();
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("abort_no_out", out_valid, 0);
        end
        check("post_rst_sat", sat_flag, 0);
        cfg_write(3, -8192);
        send_exp("state_zeroed", 0, 0, 0);
        send_exp("post_rst_500", 0, 500, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised, multi-channel cascade of second-order IIR (biquad, direct form II) sections with run-time loadable coefficients. One shared multiply-accumulate unit is time-multiplexed over all sections and channels. It replaces the fixed single-section Q1.15 notch filter in the audio conditioning path, sitting between the sample deserialiser and the downstream decimator. Valid/ready handshakes sit on both input and output.

## Interface
- DATA_W, 16: sample width, signed Q1.(DATA_W-1)
- COEF_W, 16: coefficient width, signed Q2.(COEF_W-2), so |a1| up to 2.0 is representable
- NUM_SECTIONS, 4: cascaded biquads per channel (1..8)
- NUM_CHANNELS, 2: independent channels, each with its own state (1..8)
- CH_W, max(1,$clog2(NUM_CHANNELS)): channel index width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid / in_ready  in / out  1  input sample handshake
- in_data  in  DATA_W  input sample
- in_chan  in  CH_W  channel of in_data
- out_valid / out_ready  out / in  1  output sample handshake
- out_data  out  DATA_W  filtered sample
- out_chan  out  CH_W  channel of out_data
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  $clog2(5*NUM_SECTIONS)  coefficient index = section*5 + k, where k ordering is b0,b1,b2,a1,a2
- cfg_wdata  in  COEF_W  coefficient value
- clear_state  in  1  zero all w1/w2 state for all channels
- busy  out  1  FSM not in IDLE
- sat_flag  out  1  sticky overflow indicator; cleared by reset or clear_state

## Operation
- FSM states: IDLE, MAC, OUT.
  - IDLE: in_ready=1. in_valid&&in_ready captures in_data and in_chan, sets section=0 and step=0, then goes to MAC.
- MAC performs one multiply per cycle, 5 steps per section. Products are full precision. x is aligned by <<< (COEF_W-2). ACC_W = DATA_W+COEF_W+4.
  - step0: acc = x<<<(COEF_W-2) - a1*w1.
  - step1: acc -= a2*w2. At the end of step1, w0 = sat(acc >>> (COEF_W-2)).
  - step2: acc = b0*w0.
  - step3: acc += b1*w1.
  - step4: acc += b2*w2. Section output = sat(acc >>> (COEF_W-2)) becomes x for the next section. State updates w2<=w1, w1<=w0 for (chan, section).
- After step4 of the last section, out_data and out_chan are registered and the FSM goes to OUT.
- The shift is arithmetic with floor rounding. w and section outputs are DATA_W wide.
- OUT: out_valid=1 with out_data and out_chan held stable. On out_ready, the FSM goes to IDLE.
- cfg_we and clear_state act only when in IDLE; they are ignored when busy=1. In IDLE, in_valid has priority over nothing: cfg/clear in the same cycle as acceptance are both applied, before the sample uses coefficients and state.
- Reset values: out_valid=0, out_data=0, out_chan=0, busy=0, sat_flag=0, in_ready=1 once out of reset, all w=0.
  - Coefficients reset to pass-through: b0 = 1<<(COEF_W-2), all others 0.
- Reset mid-operation aborts the sample; no output is produced for it.

## Timing
- in_ready is 1 only in IDLE, so the input is accepted at most once per 5*NUM_SECTIONS+2 cycles.
- out_valid rises 5*NUM_SECTIONS clock edges after the accepting edge. For defaults, this is 20.
- in_ready returns the cycle after the out_valid&&out_ready edge.
- Output backpressure is unbounded. Data stays stable and no input is accepted meanwhile.
- A cfg write lands on the next edge and is used by any sample accepted at or after that edge.

## Configuration
- IIR_SAT_EN defined: w and section outputs saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clip sets sat_flag.
- IIR_SAT_EN undefined: the low DATA_W bits are taken (two's-complement wrap), and sat_flag is tied 0.

## Test plan
- Reset, then send x=1000 on chan 0. Required: out_data=1000 and out_chan=0, with out_valid exactly 20 edges after acceptance.
- Section0 with b0=8192 and a1=-8192 (w0 = x + 0.5*w1), others pass-through. Impulse 16384 then zeros on chan 0. Required: outputs 8192, 4096, 2048, 1024.
- Same filter, interleave chan 0 impulse with chan 1 zeros. Required: chan 1 outputs all 0, and the chan 0 sequence matches the previous scenario.
- b0=32767, x=30000:
  - With IIR_SAT_EN: out 32767 and sat_flag=1.
  - Without IIR_SAT_EN: out -5538 and sat_flag=0.
- Hold out_ready=0 for 10 cycles. Required: out_data stable, in_ready=0, and a cfg_we during that time is ignored (read back by a later pass-through test).
- Assert reset during MAC. Required: out_valid stays 0, all state is zeroed, and the next sample 500 yields 500.
